// File: rtl/prbs_word_gen.sv
// PRBS test-data source: O.150-style LFSR with a runtime-selectable polynomial,
// packed MSB-first into DATA_W-bit words behind a ready/valid stream.
module prbs_word_gen #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        poly_sel,
    input  logic              err_inject,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              lock_err
);

    logic [30:0]       lfsr_q, lfsr_d;
    logic [2:0]        poly_q, poly_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lock_q, lock_d;

    // The all-ones mask of the active order doubles as the reseed value.
    function automatic logic [30:0] order_mask(input logic [2:0] sel);
        case (sel)
            3'd0:    return 31'h0000_007F;
            3'd1:    return 31'h0000_01FF;
            3'd2:    return 31'h0000_7FFF;
            3'd4:    return 31'h7FFF_FFFF;
            default: return 31'h007F_FFFF;
        endcase
    endfunction

    // Returns {TA-1, TB-1}: bit positions of the two polynomial taps.
    function automatic logic [9:0] tap_pair(input logic [2:0] sel);
        case (sel)
            3'd0:    return {5'd6, 5'd5};
            3'd1:    return {5'd8, 5'd4};
            3'd2:    return {5'd14, 5'd13};
            3'd4:    return {5'd30, 5'd27};
            default: return {5'd22, 5'd17};
        endcase
    endfunction

    logic [30:0]       mask, lfsr_m, step;
    logic [4:0]        tap_a, tap_b;
    logic [DATA_W-1:0] word, flip;
    logic              fb, adv, xfer, pend_now;

    always_comb begin
        mask           = order_mask(poly_q);
        {tap_a, tap_b} = tap_pair(poly_q);
        lfsr_m         = lfsr_q & mask;
        step           = lfsr_m;
        word           = '0;
        fb             = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fb   = step[tap_a] ^ step[tap_b];
            word = DATA_W'({word, fb});
            step = {step[29:0], fb} & mask;
        end
    end

    always_comb begin
        xfer     = valid_q & out_ready;
        adv      = enable & (~valid_q | out_ready);
        pend_now = pend_q | err_inject;
        flip     = '0;
        flip[DATA_W-1] = pend_now;

        lfsr_d  = lfsr_q;
        poly_d  = poly_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        pend_d  = pend_now;
        cnt_d   = cnt_q + CNT_W'(xfer);
        lock_d  = 1'b0;

        if (poly_sel != poly_q) begin
            // Restart on the new polynomial; the pending word is discarded.
            poly_d  = poly_sel;
            lfsr_d  = order_mask(poly_sel);
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (lfsr_m == '0) begin
            lfsr_d = mask;
            lock_d = 1'b1;
            if (xfer) valid_d = 1'b0;
        end else if (adv) begin
            lfsr_d  = step;
            data_d  = word ^ flip;
            err_d   = pend_now;
            pend_d  = 1'b0;
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= order_mask(poly_sel);
            poly_q  <= poly_sel;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            poly_q  <= poly_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign xfer_cnt  = cnt_q;
    assign lock_err  = lock_q;

endmodule

// File: tb/tb_prbs_word_gen.sv
// Directed bench for prbs_word_gen (DATA_W=8) with a bit-serial LFSR reference
// and hand-computed first words.
module tb_prbs_word_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  poly_sel;
    logic        err_inject;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_err;
    logic [31:0] xfer_cnt;
    logic        lock_err;

    prbs_word_gen #(.DATA_W(8), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .poly_sel   (poly_sel),
        .err_inject (err_inject),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_err    (out_err),
        .xfer_cnt   (xfer_cnt),
        .lock_err   (lock_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference LFSR
    logic [30:0] m_lfsr;
    int          m_ord, m_ta, m_tb;

    task automatic model_init(input int sel);
        case (sel)
            0:       begin m_ord = 7;  m_ta = 7;  m_tb = 6;  end
            1:       begin m_ord = 9;  m_ta = 9;  m_tb = 5;  end
            2:       begin m_ord = 15; m_ta = 15; m_tb = 14; end
            4:       begin m_ord = 31; m_ta = 31; m_tb = 28; end
            default: begin m_ord = 23; m_ta = 23; m_tb = 18; end
        endcase
        m_lfsr = '0;
        for (int i = 0; i < m_ord; i++) m_lfsr[i] = 1'b1;
    endtask

    task automatic model_word(output logic [7:0] w);
        logic b;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            b = m_lfsr[m_ta-1] ^ m_lfsr[m_tb-1];
            w = {w[6:0], b};
            m_lfsr = {m_lfsr[29:0], b};
            for (int i = m_ord; i < 31; i++) m_lfsr[i] = 1'b0;
        end
    endtask

    logic [7:0] mw, held;
    logic [7:0] first23 [3];
    logic [7:0] seq7 [130];
    int         exp_cnt;

    initial begin
        first23[0] = 8'h00; first23[1] = 8'h00; first23[2] = 8'h3E;
        reset = 1'b1; enable = 1'b0; poly_sel = 3'd3; err_inject = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_data",  out_data,  8'h00);
        check_val("rst_err",   out_err,   1'b0);
        check_val("rst_cnt",   xfer_cnt,  32'd0);
        check_val("rst_lock",  lock_err,  1'b0);

        // PRBS23 free-running
        reset = 1'b0; enable = 1'b1;
        model_init(3); exp_cnt = 0;
        for (int w = 0; w < 40; w++) begin
            if (w > 0) exp_cnt++;
            @(negedge clk);
            model_word(mw);
            check_val("p23_valid", out_valid, 1'b1);
            check_val("p23_word",  out_data,  mw);
            check_val("p23_cnt",   xfer_cnt,  exp_cnt);
            if (w < 3) check_val("p23_first", out_data, first23[w]);
        end

        // Back-pressure stall, enable dropped partway through
        held = out_data; out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s == 2) enable = 1'b0;
            @(negedge clk);
            check_val("stall_data",  out_data,  held);
            check_val("stall_valid", out_valid, 1'b1);
            check_val("stall_cnt",   xfer_cnt,  exp_cnt);
        end
        out_ready = 1'b1; exp_cnt++;
        @(negedge clk);
        check_val("drain_valid", out_valid, 1'b0);
        check_val("drain_cnt",   xfer_cnt,  exp_cnt);
        enable = 1'b1;
        @(negedge clk);
        model_word(mw);
        check_val("resume_valid", out_valid, 1'b1);
        check_val("resume_word",  out_data,  mw);
        check_val("resume_cnt",   xfer_cnt,  exp_cnt);

        // Single error pulse, then clean words
        err_inject = 1'b1; exp_cnt++;
        @(negedge clk);
        err_inject = 1'b0;
        model_word(mw);
        check_val("inj_word", out_data, mw ^ 8'h80);
        check_val("inj_err",  out_err,  1'b1);
        for (int w = 0; w < 3; w++) begin
            exp_cnt++;
            @(negedge clk);
            model_word(mw);
            check_val("clean_word", out_data, mw);
            check_val("clean_err",  out_err,  1'b0);
        end

        // Two pulses during a stall collapse into one error
        held = out_data; out_ready = 1'b0; err_inject = 1'b1;
        repeat (2) @(negedge clk);
        err_inject = 1'b0;
        @(negedge clk);
        check_val("pend_hold_data", out_data, held);
        check_val("pend_hold_err",  out_err,  1'b0);
        out_ready = 1'b1; exp_cnt++;
        @(negedge clk);
        model_word(mw);
        check_val("multi_word", out_data, mw ^ 8'h80);
        check_val("multi_err",  out_err,  1'b1);
        exp_cnt++;
        @(negedge clk);
        model_word(mw);
        check_val("multi_next_word", out_data, mw);
        check_val("multi_next_err",  out_err,  1'b0);
        check_val("multi_cnt",       xfer_cnt, exp_cnt);

        // Mode change 3 -> 4 mid-stream
        poly_sel = 3'd4; exp_cnt++;
        @(negedge clk);
        check_val("mode_valid", out_valid, 1'b0);
        check_val("mode_err",   out_err,   1'b0);
        check_val("mode_cnt",   xfer_cnt,  exp_cnt);
        @(negedge clk);
        model_init(4); model_word(mw);
        check_val("p31_valid", out_valid, 1'b1);
        check_val("p31_first", out_data,  8'h00);
        check_val("p31_word",  out_data,  mw);
        check_val("p31_cnt",   xfer_cnt,  exp_cnt);
        for (int w = 0; w < 6; w++) begin
            exp_cnt++;
            @(negedge clk);
            model_word(mw);
            check_val("p31_word", out_data, mw);
        end

        // Forced lock-up reseeds and restarts the sequence
        force dut.lfsr_q = 31'h0;
        #1 release dut.lfsr_q;
        exp_cnt++;
        @(negedge clk);
        check_val("lock_pulse", lock_err,  1'b1);
        check_val("lock_valid", out_valid, 1'b0);
        check_val("lock_cnt",   xfer_cnt,  exp_cnt);
        model_init(4);
        for (int w = 0; w < 5; w++) begin
            if (w > 0) exp_cnt++;
            @(negedge clk);
            model_word(mw);
            check_val("relock_word", out_data, mw);
            check_val("relock_cnt",  xfer_cnt, exp_cnt);
            if (w == 0) check_val("lock_clear", lock_err, 1'b0);
        end

        // Reset mid-stall
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; poly_sel = 3'd0;
        @(negedge clk);
        check_val("mid_rst_valid", out_valid, 1'b0);
        check_val("mid_rst_cnt",   xfer_cnt,  32'd0);
        check_val("mid_rst_data",  out_data,  8'h00);

        // PRBS7: first word and 127-word period
        out_ready = 1'b1; reset = 1'b0;
        model_init(0); exp_cnt = 0;
        for (int w = 0; w < 130; w++) begin
            if (w > 0) exp_cnt++;
            @(negedge clk);
            model_word(mw);
            seq7[w] = out_data;
            check_val("p7_word", out_data, mw);
            if (w == 0) check_val("p7_first", out_data, 8'h02);
            if (w >= 127) check_val("p7_period", out_data, seq7[w-127]);
        end
        check_val("p7_cnt", xfer_cnt, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
